drop_event_mon: RTL and testbench

DROP_EVENT_MON -- requirements
Module: drop_event_mon

---
 rtl/drop_event_mon.sv | 120 ++++++++++++
 tb/tb_drop_event_mon.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/drop_event_mon.sv
// drop_event_mon: counts frame EOF/drop events per cycle, queues them and serializes one event per handshake.
// Optional: define DROP_EVENT_MON_CNT_SAT_EN to make the statistics counters saturate instead of wrap.
module drop_event_mon #(
  parameter int REGIONS    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IN_SRC_RDY,
  input  logic [REGIONS-1:0]   IN_EOF,
  input  logic [REGIONS-1:0]   IN_DROP,
  input  logic                 CNT_CLEAR,
  output logic                 OUT_EVENT_VLD,
  output logic                 OUT_EVENT_DROP,
  input  logic                 OUT_EVENT_DST_RDY,
  output logic [CNT_WIDTH-1:0] CNT_FRAMES,
  output logic [CNT_WIDTH-1:0] CNT_DROPPED,
  output logic [CNT_WIDTH-1:0] CNT_LOST,
  output logic                 FIFO_FULL
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nxt;
  logic [2*REGIONS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_nxt;
  logic smp, wr, pop, hs, last, empty;
  logic [REGIONS-1:0] e, d, e_q, d_q, e_nxt, d_nxt, low;
  logic [CNT_WIDTH-1:0] inc_f, inc_d, inc_l;

  function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [REGIONS-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < REGIONS; i++) r = r + CNT_WIDTH'(v[i]);
    return r;
  endfunction

  // A clear coinciding with an increment loads the increment rather than zero.
  function automatic logic [CNT_WIDTH-1:0] upd(input logic [CNT_WIDTH-1:0] cur, input logic [CNT_WIDTH-1:0] inc,
                                               input logic clr);
`ifdef DROP_EVENT_MON_CNT_SAT_EN
    logic [CNT_WIDTH:0] s;
    s = {1'b0, (clr ? {CNT_WIDTH{1'b0}} : cur)} + {1'b0, inc};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
`else
    return (clr ? {CNT_WIDTH{1'b0}} : cur) + inc;
`endif
  endfunction

  assign e       = IN_EOF;
  assign d       = IN_EOF & IN_DROP;
  assign smp     = IN_SRC_RDY && (|IN_EOF);
  assign wr      = smp && !FIFO_FULL;
  assign empty   = cnt == '0;
  assign low     = e_q & ~(e_q - REGIONS'(1));
  assign last    = (e_q & ~low) == '0;
  assign hs      = OUT_EVENT_VLD && OUT_EVENT_DST_RDY;
  assign cnt_nxt = cnt + (AW+1)'(wr) - (AW+1)'(pop);
  assign inc_f   = smp ? popcnt(e) : '0;
  assign inc_d   = smp ? popcnt(d) : '0;
  assign inc_l   = (smp && FIFO_FULL) ? popcnt(e) : '0;
  assign OUT_EVENT_VLD  = state == EMIT;
  assign OUT_EVENT_DROP = |(d_q & low);

  // Serializer: pull the FIFO head when idle or right after the last bit of the current entry.
  always_comb begin
    state_nxt = state;
    e_nxt     = e_q;
    d_nxt     = d_q;
    pop       = 1'b0;
    if (state == IDLE) begin
      if (!empty) begin
        pop            = 1'b1;
        state_nxt      = EMIT;
        {e_nxt, d_nxt} = mem[rd_ptr];
      end
    end else if (hs) begin
      e_nxt = e_q & ~low;
      if (last && !empty) begin
        pop            = 1'b1;
        {e_nxt, d_nxt} = mem[rd_ptr];
      end else if (last) begin
        state_nxt = IDLE;
      end
    end
  end

  // FIFO storage; validity is tracked by the pointers and occupancy count.
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= {e, d};
  end

  // Control state, FIFO bookkeeping and statistics counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      e_q         <= '0;
      d_q         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      FIFO_FULL   <= 1'b0;
      CNT_FRAMES  <= '0;
      CNT_DROPPED <= '0;
      CNT_LOST    <= '0;
    end else begin
      state       <= state_nxt;
      e_q         <= e_nxt;
      d_q         <= d_nxt;
      wr_ptr      <= wr_ptr + AW'(wr);
      rd_ptr      <= rd_ptr + AW'(pop);
      cnt         <= cnt_nxt;
      FIFO_FULL   <= cnt_nxt == (AW+1)'(FIFO_DEPTH);
      CNT_FRAMES  <= upd(CNT_FRAMES, inc_f, CNT_CLEAR);
      CNT_DROPPED <= upd(CNT_DROPPED, inc_d, CNT_CLEAR);
      CNT_LOST    <= upd(CNT_LOST, inc_l, CNT_CLEAR);
    end
  end
endmodule

// File: tb/tb_drop_event_mon.sv
// tb_drop_event_mon: randomized self-checking bench with a queue-level reference model.
module tb_drop_event_mon;
  logic CLK = 1'b0, RESET_N = 1'b0, src = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [3:0] eof = '0, drp = '0;
  logic vld, drop, full;
  logic [7:0] frames, dropped, lost;
  int checks = 0, errors = 0;
  logic [7:0] fq[$];
  bit cur[$];
  bit m_emit = 0;
  int unsigned m_frames = 0, m_dropped = 0, m_lost = 0, m_ev_drops = 0;

  always #5 CLK = ~CLK;

  drop_event_mon #(.REGIONS(4), .FIFO_DEPTH(4), .CNT_WIDTH(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_SRC_RDY(src), .IN_EOF(eof), .IN_DROP(drp), .CNT_CLEAR(clr),
    .OUT_EVENT_VLD(vld), .OUT_EVENT_DROP(drop), .OUT_EVENT_DST_RDY(rdy),
    .CNT_FRAMES(frames), .CNT_DROPPED(dropped), .CNT_LOST(lost), .FIFO_FULL(full)
  );

  function automatic logic [7:0] exp8(input int unsigned raw);
`ifdef DROP_EVENT_MON_CNT_SAT_EN
    return raw > 255 ? 8'hFF : 8'(raw);
`else
    return 8'(raw);
`endif
  endfunction

  function automatic void model_reset();
    fq.delete();
    cur.delete();
    m_emit = 0;
    m_frames = 0;
    m_dropped = 0;
    m_lost = 0;
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic tick(input logic s, input logic [3:0] e, input logic [3:0] dv, input logic c, input logic r);
    logic [3:0] dd;
    logic [7:0] ent;
    bit smp, fl, ne, hs;
    int unsigned fi, di, li;
    src = s; eof = e; drp = dv; clr = c; rdy = r;
    @(posedge CLK);
    dd = e & dv;
    smp = s && (e != 0);
    fl = fq.size() == 4;
    ne = fq.size() != 0;
    hs = m_emit && r;
    fi = smp ? $countones(e) : 0;
    di = smp ? $countones(dd) : 0;
    li = (smp && fl) ? $countones(e) : 0;
    m_frames  = c ? fi : m_frames + fi;
    m_dropped = c ? di : m_dropped + di;
    m_lost    = c ? li : m_lost + li;
    if (hs) begin
      if (cur[0]) m_ev_drops++;
      void'(cur.pop_front());
      if (cur.size() == 0) m_emit = 0;
    end
    if (!m_emit && ne) begin
      ent = fq.pop_front();
      for (int i = 0; i < 4; i++) if (ent[4+i]) cur.push_back(ent[i]);
      m_emit = 1;
    end
    if (smp && !fl) fq.push_back({e, dd});
    @(negedge CLK);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (m_emit || fq.size() != 0); i++) tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", vld); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if ({frames, dropped, lost} !== 24'h0) begin
      errors++; $display("FAIL reset_counters got %h %h %h want 0", frames, dropped, lost);
    end
    RESET_N = 1'b1;
  endtask

  task automatic test_basic();
    tick(1, 4'b0101, 4'b0100, 0, 1);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL basic_vld_c1 got %b want 0", vld); end
    checks++; if (frames !== 8'd2) begin errors++; $display("FAIL basic_frames got %0d want 2", frames); end
    checks++; if (dropped !== 8'd1) begin errors++; $display("FAIL basic_dropped got %0d want 1", dropped); end
    tick(0, 0, 0, 0, 1);
    checks++; if ({vld, drop} !== 2'b10) begin errors++; $display("FAIL basic_ev0 got vld=%b drop=%b want 1/0", vld, drop); end
    tick(0, 0, 0, 0, 1);
    checks++; if ({vld, drop} !== 2'b11) begin errors++; $display("FAIL basic_ev1 got vld=%b drop=%b want 1/1", vld, drop); end
    tick(0, 0, 0, 0, 1);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", vld); end
  endtask

  task automatic test_overflow();
    int ev = 0;
    tick(1, 4'b0001, 4'b0000, 0, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b want 1", vld); end
    tick(0, 0, 0, 1, 0);
    checks++; if (frames !== 8'd0) begin errors++; $display("FAIL ovf_clear got %0d want 0", frames); end
    for (int i = 0; i < 5; i++) tick(1, 4'b1111, 4'b0000, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", full); end
    checks++; if (lost !== 8'd4) begin errors++; $display("FAIL ovf_lost got %0d want 4", lost); end
    checks++; if (frames !== 8'd20) begin errors++; $display("FAIL ovf_frames got %0d want 20", frames); end
    for (int i = 0; i < 40; i++) begin
      checks++; if (vld !== m_emit) begin errors++; $display("FAIL ovf_drain_vld cyc %0d got %b want %b", i, vld, m_emit); end
      checks++; if (full !== (fq.size() == 4)) begin errors++; $display("FAIL ovf_drain_full cyc %0d got %b want %b", i, full, fq.size() == 4); end
      if (vld === 1'b1) ev++;
      tick(0, 0, 0, 0, 1);
    end
    checks++; if (ev != 17) begin errors++; $display("FAIL ovf_events got %0d want 17", ev); end
  endtask

  task automatic test_clear();
    tick(1, 4'b0011, 4'b0001, 1, 1);
    checks++; if (frames !== 8'd2) begin errors++; $display("FAIL clear_frames got %0d want 2", frames); end
    checks++; if (dropped !== 8'd1) begin errors++; $display("FAIL clear_dropped got %0d want 1", dropped); end
    checks++; if (lost !== 8'd0) begin errors++; $display("FAIL clear_lost got %0d want 0", lost); end
    drain();
  endtask

  task automatic test_random();
    int samples = 0, obs = 0;
    logic s, c, r;
    logic [3:0] e, dv;
    m_ev_drops = 0;
    tick(0, 0, 0, 1, 0);
    for (int cyc = 0; cyc < 20000 && samples < 1000; cyc++) begin
      checks++; if (vld !== m_emit) begin errors++; $display("FAIL rnd_vld cyc %0d got %b want %b", cyc, vld, m_emit); end
      if (m_emit) begin
        checks++; if (drop !== cur[0]) begin errors++; $display("FAIL rnd_drop cyc %0d got %b want %b", cyc, drop, cur[0]); end
      end
      checks++; if (full !== (fq.size() == 4)) begin errors++; $display("FAIL rnd_full cyc %0d got %b want %b", cyc, full, fq.size() == 4); end
      checks++; if ({frames, dropped, lost} !== {exp8(m_frames), exp8(m_dropped), exp8(m_lost)}) begin
        errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", cyc, frames, dropped, lost,
                           exp8(m_frames), exp8(m_dropped), exp8(m_lost));
      end
      s = 1'($urandom_range(0, 1));
      e = 4'($urandom);
      dv = 4'($urandom);
      c = $urandom_range(0, 31) == 0;
      r = $urandom_range(0, 2) != 0;
      if (vld === 1'b1 && r && drop === 1'b1) obs++;
      if (s && e != 0) samples++;
      tick(s, e, dv, c, r);
    end
    checks++; if (samples != 1000) begin errors++; $display("FAIL rnd_budget got %0d want 1000", samples); end
    for (int i = 0; i < 60; i++) begin
      checks++; if (vld !== m_emit) begin errors++; $display("FAIL rnd_tail_vld cyc %0d got %b want %b", i, vld, m_emit); end
      if (vld === 1'b1 && drop === 1'b1) obs++;
      tick(0, 0, 0, 0, 1);
    end
    checks++; if (obs != m_ev_drops) begin errors++; $display("FAIL rnd_drop_events got %0d want %0d", obs, m_ev_drops); end
    checks++; if (dropped !== exp8(m_dropped)) begin errors++; $display("FAIL rnd_cnt_dropped got %0d want %0d", dropped, exp8(m_dropped)); end
  endtask

  task automatic test_sat();
    logic [7:0] want;
`ifdef DROP_EVENT_MON_CNT_SAT_EN
    want = 8'd255;
`else
    want = 8'd44;
`endif
    tick(0, 0, 0, 1, 1);
    for (int i = 0; i < 300; i++) tick(1, 4'(1 << (i % 4)), 4'b0000, 0, 1);
    tick(0, 0, 0, 0, 1);
    checks++; if (frames !== want) begin errors++; $display("FAIL sat_frames got %0d want %0d", frames, want); end
    checks++; if (frames !== exp8(m_frames)) begin errors++; $display("FAIL sat_model got %0d want %0d", frames, exp8(m_frames)); end
    checks++; if (dropped !== 8'd0) begin errors++; $display("FAIL sat_dropped got %0d want 0", dropped); end
    drain();
  endtask

  task automatic test_reset_mid();
    tick(1, 4'b1111, 4'b1010, 0, 0);
    tick(1, 4'b0011, 4'b0011, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    checks++; if (vld !== 1'b1 || cur.size() != 2) begin
      errors++; $display("FAIL mid_pre got vld=%b want 1 with 2 bits left (model %0d)", vld, cur.size());
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL mid_vld got %b want 0", vld); end
    checks++; if ({drop, full} !== 2'b00) begin errors++; $display("FAIL mid_flags got drop=%b full=%b want 0/0", drop, full); end
    checks++; if ({frames, dropped, lost} !== 24'h0) begin
      errors++; $display("FAIL mid_counters got %h %h %h want 0", frames, dropped, lost);
    end
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 0, 1);
      checks++; if (vld !== 1'b0) begin errors++; $display("FAIL mid_stale cyc %0d got %b want 0", i, vld); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_clear();
    test_random();
    test_sat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
